// File: rtl/traffic_intersection_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_intersection_ctrl
//
// Purpose:
//   Two-road intersection light controller. Road A and road B take turns
//   through green, yellow and all-red clearance phases. A latched pedestrian
//   request inserts a walk phase after the B->A clearance. A night request
//   diverts the sequence into a flashing-yellow mode at a clearance exit.
//   All timing advances only on cycles where the tick enable is high.
//
// Ports:
//   clk_i           clock, rising edge
//   reset_i         synchronous active-high reset, dominates all inputs
//   enable_i        tick enable; timer and state advance only when 1
//   ped_req_i       pedestrian button (level or pulse), sampled every cycle
//   night_i         night-mode request
//   red_a_o, yellow_a_o, green_a_o   road A lamps
//   red_b_o, yellow_b_o, green_b_o   road B lamps
//   walk_o          pedestrian walk lamp
//   ped_pending_o   latched pedestrian request
//   phase_o         current state code (0..7)
// ---------------------------------------------------------------------------
module traffic_intersection_ctrl #(
  parameter int CNT_W    = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PED_T    = 4,
  parameter int FLASH_T  = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       ped_req_i,
  input  logic       night_i,
  output logic       red_a_o,
  output logic       yellow_a_o,
  output logic       green_a_o,
  output logic       red_b_o,
  output logic       yellow_b_o,
  output logic       green_b_o,
  output logic       walk_o,
  output logic       ped_pending_o,
  output logic [2:0] phase_o
);

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_q,   ped_d;
  logic             flash_q, flash_d;

  // Timer reload value for a state: the state lasts duration ticks, so the
  // timer counts duration-1 down to zero and the exit fires on the zero tick.
  function automatic logic [CNT_W-1:0] loadValue(input state_e s);
    logic [CNT_W-1:0] v;
    case (s)
      A_GREEN, B_GREEN:     v = CNT_W'(GREEN_T - 1);
      A_YELLOW, B_YELLOW:   v = CNT_W'(YELLOW_T - 1);
      ALLRED_AB, ALLRED_BA: v = CNT_W'(ALLRED_T - 1);
      PED_WALK:             v = CNT_W'(PED_T - 1);
      FLASH:                v = CNT_W'(FLASH_T - 1);
      default:              v = CNT_W'(GREEN_T - 1);
    endcase
    return v;
  endfunction

  // State, timer, pedestrian latch and flash bit registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= A_GREEN;
      timer_q <= CNT_W'(GREEN_T - 1);
      ped_q   <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
    end
  end

  // Next-state logic. Night is only looked at on clearance exits and on
  // flash toggle ticks, so a running green or yellow always completes.
  // In FLASH, a zero-timer tick with night still requested toggles the
  // flash bit and reloads the half-period instead of leaving the state.
  // Entering PED_WALK clears the request latch, which also swallows a
  // button press arriving on that same edge.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ped_d   = ped_q;
    flash_d = flash_q;

    if (ped_req_i && (state_q != PED_WALK)) begin
      ped_d = 1'b1;
    end

    if (enable_i) begin
      if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end else begin
        case (state_q)
          A_GREEN:   state_d = A_YELLOW;
          A_YELLOW:  state_d = ALLRED_AB;
          ALLRED_AB: state_d = night_i ? FLASH : B_GREEN;
          B_GREEN:   state_d = B_YELLOW;
          B_YELLOW:  state_d = ALLRED_BA;
          ALLRED_BA: begin
            if (night_i) begin
              state_d = FLASH;
            end else if (ped_q) begin
              state_d = PED_WALK;
            end else begin
              state_d = A_GREEN;
            end
          end
          PED_WALK:  state_d = A_GREEN;
          FLASH: begin
            if (night_i) begin
              flash_d = ~flash_q;
              timer_d = loadValue(FLASH);
            end else begin
              state_d = ALLRED_BA;
            end
          end
          default:   state_d = A_GREEN;
        endcase

        if (state_d != state_q) begin
          timer_d = loadValue(state_d);
          if (state_d == FLASH) begin
            flash_d = 1'b1;
          end
          if (state_d == PED_WALK) begin
            ped_d = 1'b0;
          end
        end
      end
    end
  end

  // Moore lamp decode from the registered state.
  always_comb begin
    red_a_o    = 1'b0;
    yellow_a_o = 1'b0;
    green_a_o  = 1'b0;
    red_b_o    = 1'b0;
    yellow_b_o = 1'b0;
    green_b_o  = 1'b0;
    walk_o     = 1'b0;
    case (state_q)
      A_GREEN: begin
        green_a_o = 1'b1;
        red_b_o   = 1'b1;
      end
      A_YELLOW: begin
        yellow_a_o = 1'b1;
        red_b_o    = 1'b1;
      end
      B_GREEN: begin
        red_a_o   = 1'b1;
        green_b_o = 1'b1;
      end
      B_YELLOW: begin
        red_a_o    = 1'b1;
        yellow_b_o = 1'b1;
      end
      ALLRED_AB, ALLRED_BA: begin
        red_a_o = 1'b1;
        red_b_o = 1'b1;
      end
      PED_WALK: begin
        red_a_o = 1'b1;
        red_b_o = 1'b1;
        walk_o  = 1'b1;
      end
      FLASH: begin
        yellow_a_o = flash_q;
        yellow_b_o = flash_q;
      end
      default: begin
        red_a_o = 1'b1;
        red_b_o = 1'b1;
      end
    endcase
  end

  assign ped_pending_o = ped_q;
  assign phase_o       = state_q;

endmodule
